if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 110 +++++++++++
 tb/tb_if_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, imem request and IF/ID register; optional stall counter under IF_STAGE_STALL_CNT_EN.
// Latency: one cycle from an accepted imem word to if_out/if_valid.
// Backpressure: freeze holds PC and IF/ID, a word returned during freeze is parked in a one-word buffer (HELD).
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [63:0] if_out,
    output logic        if_valid,
    output logic [15:0] stall_cnt
);

    typedef enum logic {FETCH = 1'b0, HELD = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] word_buf, word_buf_nxt;
    logic [63:0] if_out_nxt;
    logic        if_valid_nxt;
    logic [31:0] pc_plus4;

    // Wraps modulo 2^32 naturally; branch targets are taken unaligned as given.
    assign pc_plus4  = pc + 32'd4;
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            word_buf <= 32'h0;
            if_out   <= 64'h0;
            if_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            word_buf <= word_buf_nxt;
            if_out   <= if_out_nxt;
            if_valid <= if_valid_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        word_buf_nxt = word_buf;
        if_out_nxt   = if_out;
        if_valid_nxt = if_valid;
        if (branch_taken) begin
            // Redirect wins over everything; any in-flight or buffered word is dropped.
            state_nxt    = FETCH;
            pc_nxt       = branch_addr;
            word_buf_nxt = 32'h0;
            if_out_nxt   = 64'h0;
            if_valid_nxt = 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        if (freeze) begin
                            word_buf_nxt = imem_rdata;
                            state_nxt    = HELD;
                        end else begin
                            if_out_nxt   = {pc_plus4, imem_rdata};
                            if_valid_nxt = 1'b1;
                            pc_nxt       = pc_plus4;
                        end
                    end else if (!freeze) begin
                        if_out_nxt   = 64'h0;
                        if_valid_nxt = 1'b0;
                    end
                end
                HELD: begin
                    if (!freeze) begin
                        if_out_nxt   = {pc_plus4, word_buf};
                        if_valid_nxt = 1'b1;
                        pc_nxt       = pc_plus4;
                        state_nxt    = FETCH;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

`ifdef IF_STAGE_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'h0;
        end else if (imem_req && !imem_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random traffic, all checked against a transaction-level model.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, freeze, branch_taken, imem_ready;
    logic [31:0] branch_addr, imem_rdata;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr;
    logic [63:0] if_out;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: PC, last delivered item, parked words and wait count.
    logic [31:0] m_pc;
    logic [63:0] m_out;
    logic        m_valid;
    logic [31:0] m_park[$];
    int          m_waits;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_out(if_out),
        .if_valid(if_valid), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt();
`ifdef IF_STAGE_STALL_CNT_EN
        return (m_waits > 65535) ? 16'hFFFF : 16'(m_waits);
`else
        return 16'h0000;
`endif
    endfunction

    // Advance one clock: evaluate the model on the pre-edge inputs, then compare every output.
    task automatic cyc(input string tag);
        logic fetching;
        fetching = (m_park.size() == 0);
        if (rst) begin
            m_pc = RST_PC; m_out = 64'h0; m_valid = 1'b0; m_park.delete(); m_waits = 0;
        end else begin
            if (fetching && !imem_ready) m_waits++;
            if (branch_taken) begin
                m_pc = branch_addr; m_out = 64'h0; m_valid = 1'b0; m_park.delete();
            end else if (!fetching) begin
                if (!freeze) begin
                    m_out = {m_pc + 32'd4, m_park.pop_front()}; m_valid = 1'b1; m_pc += 32'd4;
                end
            end else if (imem_ready) begin
                if (freeze) m_park.push_back(imem_rdata);
                else begin
                    m_out = {m_pc + 32'd4, imem_rdata}; m_valid = 1'b1; m_pc += 32'd4;
                end
            end else if (!freeze) begin
                m_out = 64'h0; m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".req"},   64'(imem_req),  64'(m_park.size() == 0));
        chk({tag, ".addr"},  64'(imem_addr), 64'(m_pc));
        chk({tag, ".out"},   if_out,         m_out);
        chk({tag, ".valid"}, 64'(if_valid),  64'(m_valid));
        chk({tag, ".cnt"},   64'(stall_cnt), 64'(exp_cnt()));
    endtask

    task automatic drive(input logic r, input logic fz, input logic br, input logic [31:0] ba,
                         input logic rdy, input logic [31:0] rd);
        rst = r; freeze = fz; branch_taken = br; branch_addr = ba; imem_ready = rdy; imem_rdata = rd;
    endtask

    initial begin
        m_pc = RST_PC; m_out = 64'h0; m_valid = 1'b0; m_waits = 0;

        // Reset
        drive(1, 0, 0, 32'h0, 0, 32'h0);
        cyc("rst0");
        cyc("rst1");
        chk("rst_req", 64'(imem_req), 64'h1);
        chk("rst_addr", 64'(imem_addr), 64'(RST_PC));

        // Back-to-back fetch
        drive(0, 0, 0, 32'h0, 1, 32'hE3A0_1005);
        cyc("fetch0");
        chk("fetch0_out", if_out, 64'h0000_0004_E3A0_1005);
        chk("fetch0_addr", 64'(imem_addr), 64'h4);
        drive(0, 0, 0, 32'h0, 1, 32'hA5A5_0001);
        cyc("fetch1");

        // Three memory waits at pc 0x8
        drive(0, 0, 0, 32'h0, 0, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) cyc("wait");
        chk("wait_addr", 64'(imem_addr), 64'h8);
        chk("wait_valid", 64'(if_valid), 64'h0);
`ifdef IF_STAGE_STALL_CNT_EN
        chk("wait_cnt", 64'(stall_cnt), 64'h3);
`else
        chk("wait_cnt", 64'(stall_cnt), 64'h0);
`endif

        // Freeze with a word returning at pc 0xC
        drive(0, 0, 0, 32'h0, 1, 32'h0BAD_0008);
        cyc("fetch8");
        drive(0, 1, 0, 32'h0, 1, 32'h1234_5678);
        cyc("frz_cap");
        chk("held_req", 64'(imem_req), 64'h0);
        drive(0, 1, 0, 32'h0, 1, 32'h5555_5555);
        cyc("frz_hold1");
        cyc("frz_hold2");
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        cyc("frz_rel");
        chk("frz_rel_out", if_out, 64'h0000_0010_1234_5678);

        // Branch while frozen in HELD drops the parked word
        drive(0, 1, 0, 32'h0, 1, 32'hDEAD_BEEF);
        cyc("hold2");
        drive(0, 1, 1, 32'h0000_0100, 1, 32'h7777_7777);
        cyc("br_held");
        chk("br_valid", 64'(if_valid), 64'h0);
        chk("br_addr", 64'(imem_addr), 64'h100);
        chk("br_req", 64'(imem_req), 64'h1);
        drive(0, 0, 0, 32'h0, 1, 32'h0000_C0DE);
        cyc("br_after");
        chk("br_after_out", if_out, 64'h0000_0104_0000_C0DE);

        // PC wrap
        drive(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0);
        cyc("br_wrap");
        drive(0, 0, 0, 32'h0, 1, 32'h1111_2222);
        cyc("wrap");
        chk("wrap_hi", 64'(if_out[63:32]), 64'h0);
        chk("wrap_addr", 64'(imem_addr), 64'h0);

        // Reset while in HELD
        drive(0, 1, 0, 32'h0, 1, 32'h3333_4444);
        cyc("hold3");
        drive(1, 1, 0, 32'h0, 1, 32'h0);
        cyc("rst_held");
        chk("rh_addr", 64'(imem_addr), 64'(RST_PC));
        chk("rh_out", if_out, 64'h0);
        chk("rh_req", 64'(imem_req), 64'h1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0), $urandom(),
                  ($urandom_range(0, 3) != 0), $urandom());
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
